// File: rtl/usb_desc_reader.sv
// EP0 GET_DESCRIPTOR responder: selects a descriptor from the ROM table and streams it in MAXPKT chunks.
// Optional feature: define USB_DESC_OTHER_SPEED_EN to answer other-speed configuration (type 7) requests.
module usb_desc_reader #(
    parameter int MAXPKT = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_setup_val,
    input  logic [7:0]  i_bmreqtype,
    input  logic [7:0]  i_breq,
    input  logic [15:0] i_wvalue,
    input  logic [15:0] i_wlength,
    input  logic        i_hs_mode,
    input  logic [9:0]  i_desc_dev_addr,
    input  logic [9:0]  i_desc_qual_addr,
    input  logic [9:0]  i_desc_fscfg_addr,
    input  logic [9:0]  i_desc_hscfg_addr,
    input  logic [9:0]  i_desc_strlang_addr,
    input  logic [9:0]  i_desc_strvendor_addr,
    input  logic [9:0]  i_desc_strproduct_addr,
    input  logic [9:0]  i_desc_strserial_addr,
    input  logic [7:0]  i_desc_dev_len,
    input  logic [7:0]  i_desc_qual_len,
    input  logic [7:0]  i_desc_fscfg_len,
    input  logic [7:0]  i_desc_hscfg_len,
    input  logic [7:0]  i_desc_strvendor_len,
    input  logic [7:0]  i_desc_strproduct_len,
    input  logic [7:0]  i_desc_strserial_len,
    input  logic        i_descrom_have_strings,
    output logic [9:0]  o_descrom_raddr,
    input  logic [7:0]  i_descrom_rdat,
    output logic [7:0]  o_tx_dat,
    output logic        o_tx_val,
    input  logic        i_tx_rdy,
    output logic        o_tx_last,
    output logic        o_tx_zlp,
    input  logic        i_pkt_ack,
    input  logic        i_pkt_retry,
    input  logic        i_status_done,
    output logic        o_busy,
    output logic        o_stall
);

    localparam int PKT_W = $clog2(MAXPKT);
    localparam logic [7:0] STRLANG_LEN = 8'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_SEND, S_WAIT_ACK, S_ZLP, S_DONE, S_STALL
    } state_t;

    state_t state, state_nx;

    logic [7:0]  req_type, req_code;
    logic [15:0] req_value, req_length;
    logic [9:0]  desc_base;
    logic [15:0] xfer_len, pkt_base, offset;
    logic        zlp_need, zlp_sent;

    logic        is_other, cfg_want_hs, cfg_use_hs;
    logic [9:0]  cfg_addr, sel_addr;
    logic [7:0]  cfg_len, sel_len;
    logic        sel_known, sel_stall, sel_zlp;
    logic [15:0] sel_len16, sel_n;
    logic        pkt_ack, pkt_retry, byte_fire;

`ifdef USB_DESC_OTHER_SPEED_EN
    logic other_speed;
    assign is_other = (req_value[15:8] == 8'd7);
`else
    assign is_other = 1'b0;
`endif

    // An empty config slot falls back to the other speed's descriptor.
    assign cfg_want_hs = i_hs_mode ^ is_other;
    assign cfg_use_hs  = cfg_want_hs ? (i_desc_hscfg_len != 8'd0) : (i_desc_fscfg_len == 8'd0);
    assign cfg_addr    = cfg_use_hs ? i_desc_hscfg_addr : i_desc_fscfg_addr;
    assign cfg_len     = cfg_use_hs ? i_desc_hscfg_len  : i_desc_fscfg_len;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sel_addr  = '0;
        sel_len   = '0;
        sel_known = 1'b1;
        case (req_value[15:8])
            8'd1: begin sel_addr = i_desc_dev_addr;  sel_len = i_desc_dev_len;  end
            8'd2: begin sel_addr = cfg_addr;         sel_len = cfg_len;         end
            8'd6: begin sel_addr = i_desc_qual_addr; sel_len = i_desc_qual_len; end
`ifdef USB_DESC_OTHER_SPEED_EN
            8'd7: begin sel_addr = cfg_addr;         sel_len = cfg_len;         end
`endif
            8'd3: begin
                if (!i_descrom_have_strings) begin
                    sel_known = 1'b0;
                end else begin
                    case (req_value[7:0])
                        8'd0: begin sel_addr = i_desc_strlang_addr;    sel_len = STRLANG_LEN;           end
                        8'd1: begin sel_addr = i_desc_strvendor_addr;  sel_len = i_desc_strvendor_len;  end
                        8'd2: begin sel_addr = i_desc_strproduct_addr; sel_len = i_desc_strproduct_len; end
                        8'd3: begin sel_addr = i_desc_strserial_addr;  sel_len = i_desc_strserial_len;  end
                        default: sel_known = 1'b0;
                    endcase
                end
            end
            default: sel_known = 1'b0;
        endcase
    end

    assign sel_stall = !sel_known || (sel_len == 8'd0) || (req_type != 8'h80) || (req_code != 8'h06);
    assign sel_len16 = {8'h00, sel_len};
    assign sel_n     = (req_length < sel_len16) ? req_length : sel_len16;
    assign sel_zlp   = (sel_n < req_length) && (sel_n[PKT_W-1:0] == '0);

    assign byte_fire = (state == S_SEND) && i_tx_rdy;
    assign pkt_ack   = (state == S_WAIT_ACK) && i_pkt_ack;
    assign pkt_retry = (state == S_WAIT_ACK) && !i_pkt_ack && i_pkt_retry;

    always_comb begin
        state_nx = state;
        case (state)
            S_LOOKUP: begin
                if (sel_stall)                 state_nx = S_STALL;
                else if (req_length == 16'd0)  state_nx = S_IDLE;
                else if (sel_n == 16'd0)       state_nx = S_ZLP;
                else                           state_nx = S_SEND;
            end
            S_SEND: begin
                if (i_status_done)                 state_nx = S_IDLE;
                else if (byte_fire && o_tx_last)   state_nx = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (i_status_done)                 state_nx = S_IDLE;
                else if (pkt_ack) begin
                    if (offset < xfer_len)         state_nx = S_SEND;
                    else if (zlp_need && !zlp_sent) state_nx = S_ZLP;
                    else                           state_nx = S_DONE;
                end else if (pkt_retry) begin
                    state_nx = zlp_sent ? S_ZLP : S_SEND;
                end
            end
            S_ZLP:  state_nx = i_status_done ? S_IDLE : S_WAIT_ACK;
            S_DONE: if (i_status_done) state_nx = S_IDLE;
            default: state_nx = state;
        endcase
        if (i_setup_val) state_nx = S_LOOKUP;
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            req_type        <= '0;
            req_code        <= '0;
            req_value       <= '0;
            req_length      <= '0;
            desc_base       <= '0;
            o_descrom_raddr <= '0;
            xfer_len        <= '0;
            pkt_base        <= '0;
            offset          <= '0;
            zlp_need        <= 1'b0;
            zlp_sent        <= 1'b0;
`ifdef USB_DESC_OTHER_SPEED_EN
            other_speed     <= 1'b0;
`endif
        end else begin
            if (i_setup_val) begin
                req_type   <= i_bmreqtype;
                req_code   <= i_breq;
                req_value  <= i_wvalue;
                req_length <= i_wlength;
            end
            case (state)
                S_LOOKUP: begin
                    desc_base       <= sel_addr;
                    o_descrom_raddr <= sel_addr;
                    xfer_len        <= sel_n;
                    zlp_need        <= sel_zlp;
                    pkt_base        <= '0;
                    offset          <= '0;
                    zlp_sent        <= 1'b0;
`ifdef USB_DESC_OTHER_SPEED_EN
                    other_speed     <= is_other;
`endif
                end
                S_SEND: begin
                    if (i_tx_rdy) begin
                        offset          <= offset + 16'd1;
                        o_descrom_raddr <= o_descrom_raddr + 10'd1;
                    end
                end
                S_WAIT_ACK: begin
                    if (pkt_ack) begin
                        pkt_base <= offset;
                    end else if (pkt_retry) begin
                        offset          <= pkt_base;
                        o_descrom_raddr <= desc_base + pkt_base[9:0];
                    end
                end
                S_ZLP: zlp_sent <= 1'b1;
                default: ;
            endcase
        end
    end

    assign o_tx_val  = (state == S_SEND);
    assign o_tx_zlp  = (state == S_ZLP);
    assign o_stall   = (state == S_STALL);
    assign o_busy    = (state == S_LOOKUP) || (state == S_SEND) || (state == S_WAIT_ACK) ||
                       (state == S_ZLP) || (state == S_DONE);
    assign o_tx_last = (state == S_SEND) &&
                       (((offset - pkt_base) == 16'(MAXPKT - 1)) || (offset == xfer_len - 16'd1));

`ifdef USB_DESC_OTHER_SPEED_EN
    // Other-speed requests report bDescriptorType 7 in place of the stored config type.
    assign o_tx_dat = (other_speed && offset == 16'd1) ? 8'h07 : i_descrom_rdat;
`else
    assign o_tx_dat = i_descrom_rdat;
`endif

endmodule

// File: tb/tb_usb_desc_reader.sv
// Self-checking bench for usb_desc_reader: random ROM contents and requests against a table-lookup model.
module tb_usb_desc_reader;

    localparam int MAXPKT = 64;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        i_setup_val = 1'b0;
    logic [7:0]  i_bmreqtype = '0, i_breq = '0;
    logic [15:0] i_wvalue = '0, i_wlength = '0;
    logic        i_hs_mode = 1'b0;
    logic [9:0]  dev_a, qual_a, fs_a, hs_a, lang_a, vend_a, prod_a, ser_a;
    logic [7:0]  dev_l, qual_l, fs_l, hs_l, vend_l, prod_l, ser_l;
    logic        have_str;
    logic [9:0]  o_descrom_raddr;
    logic [7:0]  i_descrom_rdat, o_tx_dat;
    logic        o_tx_val, o_tx_last, o_tx_zlp, o_busy, o_stall;
    logic        i_tx_rdy = 1'b0, i_pkt_ack = 1'b0, i_pkt_retry = 1'b0, i_status_done = 1'b0;

    logic [7:0] rom [1024];
    int checks = 0;
    int errors = 0;

    assign i_descrom_rdat = rom[o_descrom_raddr];
    always #5 CLK = ~CLK;

    usb_desc_reader #(.MAXPKT(MAXPKT)) dut (
        .CLK(CLK), .RESET(RESET),
        .i_setup_val(i_setup_val), .i_bmreqtype(i_bmreqtype), .i_breq(i_breq),
        .i_wvalue(i_wvalue), .i_wlength(i_wlength), .i_hs_mode(i_hs_mode),
        .i_desc_dev_addr(dev_a), .i_desc_qual_addr(qual_a), .i_desc_fscfg_addr(fs_a),
        .i_desc_hscfg_addr(hs_a), .i_desc_strlang_addr(lang_a), .i_desc_strvendor_addr(vend_a),
        .i_desc_strproduct_addr(prod_a), .i_desc_strserial_addr(ser_a),
        .i_desc_dev_len(dev_l), .i_desc_qual_len(qual_l), .i_desc_fscfg_len(fs_l),
        .i_desc_hscfg_len(hs_l), .i_desc_strvendor_len(vend_l), .i_desc_strproduct_len(prod_l),
        .i_desc_strserial_len(ser_l), .i_descrom_have_strings(have_str),
        .o_descrom_raddr(o_descrom_raddr), .i_descrom_rdat(i_descrom_rdat),
        .o_tx_dat(o_tx_dat), .o_tx_val(o_tx_val), .i_tx_rdy(i_tx_rdy), .o_tx_last(o_tx_last),
        .o_tx_zlp(o_tx_zlp), .i_pkt_ack(i_pkt_ack), .i_pkt_retry(i_pkt_retry),
        .i_status_done(i_status_done), .o_busy(o_busy), .o_stall(o_stall)
    );

    task automatic set_default_tables();
        dev_a  = 10'h000; dev_l  = 8'd18;
        qual_a = 10'h020; qual_l = 8'd10;
        fs_a   = 10'h040; fs_l   = 8'd32;
        hs_a   = 10'h080; hs_l   = 8'd64;
        lang_a = 10'h100;
        vend_a = 10'h110; vend_l = 8'd20;
        prod_a = 10'h130; prod_l = 8'd30;
        ser_a  = 10'h3fa; ser_l  = 8'd26;
        have_str = 1'b1;
        i_hs_mode = 1'b0;
    endtask

    // Reference: which descriptor a request names, how many bytes go out, and whether a ZLP closes it.
    function automatic void model(input logic [7:0] bt, input logic [7:0] br, input logic [15:0] wv,
                                  input logic [15:0] wl, output bit stall, output logic [9:0] base,
                                  output int n, output bit zlp, output bit other);
        int len = 0;
        int wl_i = int'(wl);
        bit want_hs = i_hs_mode;
        stall = 0; base = '0; other = 0;
        case (wv[15:8])
            8'd1: begin base = dev_a; len = dev_l; end
            8'd6: begin base = qual_a; len = qual_l; end
            8'd2, 8'd7: begin
                if (wv[15:8] == 8'd7) begin
`ifdef USB_DESC_OTHER_SPEED_EN
                    want_hs = !i_hs_mode; other = 1;
`else
                    stall = 1;
`endif
                end
                if ((want_hs && hs_l != 0) || (!want_hs && fs_l == 0)) begin base = hs_a; len = hs_l; end
                else begin base = fs_a; len = fs_l; end
            end
            8'd3: begin
                if (!have_str || wv[7:0] > 8'd3) stall = 1;
                else if (wv[7:0] == 8'd0) begin base = lang_a; len = 4; end
                else if (wv[7:0] == 8'd1) begin base = vend_a; len = vend_l; end
                else if (wv[7:0] == 8'd2) begin base = prod_a; len = prod_l; end
                else begin base = ser_a; len = ser_l; end
            end
            default: stall = 1;
        endcase
        if (bt != 8'h80 || br != 8'h06 || len == 0) stall = 1;
        n = (wl_i < len) ? wl_i : len;
        zlp = (n < wl_i) && (n % MAXPKT == 0);
    endfunction

    function automatic logic [7:0] exp_byte(input logic [9:0] base, input int off, input bit other);
        logic [9:0] a;
        a = base + 10'(off);
        if (other && off == 1) return 8'h07;
        return rom[a];
    endfunction

    task automatic do_setup(input logic [7:0] bt, input logic [7:0] br, input logic [15:0] wv,
                            input logic [15:0] wl);
        @(negedge CLK);
        i_bmreqtype = bt; i_breq = br; i_wvalue = wv; i_wlength = wl;
        i_setup_val = 1'b1; i_tx_rdy = 1'b0; i_pkt_ack = 1'b0; i_pkt_retry = 1'b0;
        @(negedge CLK);
        i_setup_val = 1'b0;
    endtask

    // Runs one control read end to end; retry_pkt names the packet (ZLP included) to NAK once.
    task automatic run_xfer(input logic [7:0] bt, input logic [7:0] br, input logic [15:0] wv,
                            input logic [15:0] wl, input int retry_pkt, input bit rand_rdy);
        bit stall, zlp, other, zlp_sent, retried, r;
        logic [9:0] base, exp_addr;
        int n, pb, plen, k, pkt_idx, budget;
        logic [7:0] eb;
        model(bt, br, wv, wl, stall, base, n, zlp, other);
        do_setup(bt, br, wv, wl);
        if (stall) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge CLK);
                checks++;
                if (o_stall !== 1'b1 || o_tx_val !== 1'b0 || o_busy !== 1'b0 || o_tx_zlp !== 1'b0) begin
                    errors++;
                    $display("FAIL stall wv=%h: stall=%b val=%b busy=%b zlp=%b, want stall=1 others 0",
                             wv, o_stall, o_tx_val, o_busy, o_tx_zlp);
                end
            end
            return;
        end
        if (wl == 16'd0) begin
            @(negedge CLK);
            checks++;
            if (o_busy !== 1'b0 || o_tx_val !== 1'b0 || o_stall !== 1'b0 || o_tx_zlp !== 1'b0) begin
                errors++;
                $display("FAIL wlength0: busy=%b val=%b stall=%b zlp=%b, want all 0",
                         o_busy, o_tx_val, o_stall, o_tx_zlp);
            end
            return;
        end
        pb = 0; pkt_idx = 0; zlp_sent = 0; retried = 0; plen = 0;
        while (1) begin
            if (pb < n) begin
                plen = (n - pb < MAXPKT) ? n - pb : MAXPKT;
                k = 0; budget = 0;
                while (k < plen) begin
                    @(negedge CLK);
                    i_pkt_ack = 1'b0; i_pkt_retry = 1'b0;
                    eb = exp_byte(base, pb + k, other);
                    checks++;
                    if (o_tx_val !== 1'b1 || o_tx_dat !== eb || o_tx_last !== (k == plen - 1)) begin
                        errors++;
                        $display("FAIL data off=%0d: val=%b dat=%h last=%b, want val=1 dat=%h last=%b",
                                 pb + k, o_tx_val, o_tx_dat, o_tx_last, eb, (k == plen - 1));
                    end
                    r = (!rand_rdy || budget > 200) ? 1'b1 : 1'($urandom_range(0, 1));
                    i_tx_rdy = r;
                    budget++;
                    if (r) k++;
                end
                @(negedge CLK);
                i_tx_rdy = 1'b0;
                checks++;
                if (o_tx_val !== 1'b0 || o_busy !== 1'b1 || o_tx_zlp !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_ack: val=%b busy=%b zlp=%b, want 0 1 0", o_tx_val, o_busy, o_tx_zlp);
                end
            end else if (zlp && !zlp_sent) begin
                plen = 0;
                @(negedge CLK);
                i_pkt_ack = 1'b0; i_pkt_retry = 1'b0;
                checks++;
                if (o_tx_zlp !== 1'b1 || o_tx_val !== 1'b0) begin
                    errors++;
                    $display("FAIL zlp pulse: zlp=%b val=%b, want 1 0", o_tx_zlp, o_tx_val);
                end
                @(negedge CLK);
                checks++;
                if (o_tx_zlp !== 1'b0 || o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL zlp width: zlp=%b busy=%b, want 0 1", o_tx_zlp, o_busy);
                end
                zlp_sent = 1;
            end else begin
                break;
            end
            if (pkt_idx == retry_pkt && !retried) begin
                i_pkt_retry = 1'b1;
                retried = 1;
                zlp_sent = 0;
            end else begin
                i_pkt_ack = 1'b1;
                i_pkt_retry = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
                pb += plen;
                pkt_idx++;
            end
        end
        exp_addr = base + 10'(n);
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            i_pkt_ack = 1'b0; i_pkt_retry = 1'b0;
            checks++;
            if (o_busy !== 1'b1 || o_tx_val !== 1'b0 || o_tx_zlp !== 1'b0 || o_descrom_raddr !== exp_addr) begin
                errors++;
                $display("FAIL done hold: busy=%b val=%b zlp=%b raddr=%h, want 1 0 0 %h",
                         o_busy, o_tx_val, o_tx_zlp, o_descrom_raddr, exp_addr);
            end
        end
        i_status_done = 1'b1;
        @(negedge CLK);
        i_status_done = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL status_done: busy=%b stall=%b, want 0 0", o_busy, o_stall);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        #1;
        checks++;
        if ({o_tx_val, o_tx_last, o_tx_zlp, o_busy, o_stall} !== 5'b0 || o_descrom_raddr !== 10'd0) begin
            errors++;
            $display("FAIL reset: outs=%b raddr=%h, want 0", {o_tx_val, o_tx_last, o_tx_zlp, o_busy, o_stall},
                     o_descrom_raddr);
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_device();
        run_xfer(8'h80, 8'h06, 16'h0100, 16'd64, -1, 1'b0);
    endtask

    task automatic test_config_zlp();
        i_hs_mode = 1'b1;
        run_xfer(8'h80, 8'h06, 16'h0200, 16'd255, -1, 1'b0);
        run_xfer(8'h80, 8'h06, 16'h0200, 16'd255, 1, 1'b0);
        hs_l = 8'd0;
        run_xfer(8'h80, 8'h06, 16'h0200, 16'd16, -1, 1'b0);
        set_default_tables();
    endtask

    task automatic test_truncate();
        run_xfer(8'h80, 8'h06, 16'h0100, 16'd8, -1, 1'b0);
        run_xfer(8'h80, 8'h06, 16'h0100, 16'd0, -1, 1'b0);
    endtask

    task automatic test_retry();
        run_xfer(8'h80, 8'h06, 16'h0100, 16'd64, 0, 1'b0);
        run_xfer(8'h80, 8'h06, 16'h0303, 16'd64, 0, 1'b0);
    endtask

    task automatic test_stall();
        prod_l = 8'd0;
        run_xfer(8'h80, 8'h06, 16'h0302, 16'd64, -1, 1'b0);
        set_default_tables();
        run_xfer(8'h80, 8'h00, 16'h0100, 16'd64, -1, 1'b0);
        run_xfer(8'h80, 8'h06, 16'h0700, 16'd64, -1, 1'b0);
        run_xfer(8'h80, 8'h06, 16'h0304, 16'd64, -1, 1'b0);
        have_str = 1'b0;
        run_xfer(8'h80, 8'h06, 16'h0300, 16'd64, -1, 1'b0);
        set_default_tables();
        run_xfer(8'h00, 8'h06, 16'h0100, 16'd64, -1, 1'b0);
    endtask

    task automatic test_abort();
        do_setup(8'h80, 8'h06, 16'h0100, 16'd64);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            checks++;
            if (o_tx_val !== 1'b1 || o_tx_dat !== rom[dev_a + 10'(k)]) begin
                errors++;
                $display("FAIL abort pre off=%0d: val=%b dat=%h, want 1 %h", k, o_tx_val, o_tx_dat,
                         rom[dev_a + 10'(k)]);
            end
            i_tx_rdy = 1'b1;
        end
        i_hs_mode = 1'b1;
        run_xfer(8'h80, 8'h06, 16'h0200, 16'd100, -1, 1'b0);
        i_hs_mode = 1'b0;
        do_setup(8'h80, 8'h06, 16'h0100, 16'd64);
        @(negedge CLK);
        i_status_done = 1'b1;
        @(negedge CLK);
        i_status_done = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_tx_val !== 1'b0) begin
            errors++;
            $display("FAIL status abort: busy=%b val=%b, want 0 0", o_busy, o_tx_val);
        end
    endtask

    task automatic test_reset_mid();
        do_setup(8'h80, 8'h06, 16'h0100, 16'd64);
        @(negedge CLK);
        i_tx_rdy = 1'b1;
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        checks++;
        if ({o_tx_val, o_tx_last, o_tx_zlp, o_busy, o_stall} !== 5'b0 || o_descrom_raddr !== 10'd0) begin
            errors++;
            $display("FAIL reset mid: outs=%b raddr=%h, want 0", {o_tx_val, o_tx_last, o_tx_zlp, o_busy, o_stall},
                     o_descrom_raddr);
        end
        @(negedge CLK);
        RESET = 1'b0;
        i_tx_rdy = 1'b0;
    endtask

    task automatic test_backpressure();
        do_setup(8'h80, 8'h06, 16'h0100, 16'd64);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            checks++;
            if (o_tx_val !== 1'b1 || o_tx_dat !== rom[dev_a] || o_tx_last !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: val=%b dat=%h last=%b, want 1 %h 0", c, o_tx_val, o_tx_dat,
                         o_tx_last, rom[dev_a]);
            end
        end
        run_xfer(8'h80, 8'h06, 16'h0100, 16'd64, -1, 1'b1);
        i_hs_mode = 1'b1;
        run_xfer(8'h80, 8'h06, 16'h0200, 16'd200, 1, 1'b1);
        set_default_tables();
    endtask

    function automatic logic [7:0] pick_len();
        case ($urandom_range(0, 5))
            0: return 8'd0;
            1: return 8'd64;
            2: return 8'd128;
            default: return 8'($urandom_range(1, 255));
        endcase
    endfunction

    task automatic test_random();
        logic [7:0] types [7] = '{8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd0, 8'd5};
        logic [7:0] bt, br, ty, idx;
        logic [15:0] wl;
        for (int t = 0; t < 40; t++) begin
            dev_a = 10'($urandom_range(0, 1023)); qual_a = 10'($urandom_range(0, 1023));
            fs_a  = 10'($urandom_range(0, 1023)); hs_a   = 10'($urandom_range(0, 1023));
            lang_a = 10'($urandom_range(0, 1023)); vend_a = 10'($urandom_range(0, 1023));
            prod_a = 10'($urandom_range(0, 1023)); ser_a  = 10'($urandom_range(0, 1023));
            dev_l = pick_len(); qual_l = pick_len(); fs_l = pick_len(); hs_l = pick_len();
            vend_l = pick_len(); prod_l = pick_len(); ser_l = pick_len();
            have_str = ($urandom_range(0, 3) != 0);
            i_hs_mode = 1'($urandom_range(0, 1));
            bt = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h80;
            br = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h06;
            ty = types[$urandom_range(0, 6)];
            idx = 8'($urandom_range(0, 4));
            case ($urandom_range(0, 4))
                0: wl = 16'd0;
                1: wl = 16'd64;
                2: wl = 16'd128;
                3: wl = 16'($urandom_range(1, 300));
                default: wl = 16'($urandom_range(1, 20));
            endcase
            run_xfer(bt, br, {ty, idx}, wl, int'($urandom_range(0, 4)) - 1, 1'b1);
        end
        set_default_tables();
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) rom[a] = 8'($urandom);
        set_default_tables();
        test_reset();
        test_device();
        test_config_zlp();
        test_truncate();
        test_retry();
        test_stall();
        test_abort();
        test_reset_mid();
        test_backpressure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_desc_reader.md
# usb_desc_reader

EP0 GET_DESCRIPTOR responder. Decodes a latched SETUP request and selects a descriptor from the descriptor ROM using the address/length table that ROM exports. Reads the ROM byte by byte and streams the data-stage payload to the EP0 IN packet engine in MaxPacketSize chunks, with wLength truncation, zero-length-packet (ZLP) termination and packet retry. Sits between the control-transfer decoder and the descriptor ROM.

## Interface
- MAXPKT, 64: EP0 max packet size in bytes, power of two, 8..64.
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- i_setup_val  in  1  one-cycle strobe: new SETUP fields valid
- i_bmreqtype, i_breq  in  8 each  SETUP bmRequestType, bRequest
- i_wvalue, i_wlength  in  16 each  SETUP wValue, wLength
- i_hs_mode  in  1  1 = link running high speed
- i_desc_*_addr  in  10  table addresses: dev, qual, fscfg, hscfg, strlang, strvendor, strproduct, strserial
- i_desc_*_len  in  8  matching lengths (strlang length fixed at 4)
- i_descrom_have_strings  in  1  string descriptors present
- o_descrom_raddr  out  10  ROM read address (registered)
- i_descrom_rdat  in  8  ROM data, combinational from o_descrom_raddr
- o_tx_dat  out  8  payload byte (= i_descrom_rdat, except byte 1 override, see Configuration)
- o_tx_val  out  1  byte valid
- i_tx_rdy  in  1  packet engine accepts byte
- o_tx_last  out  1  marks the final byte of the current packet
- o_tx_zlp  out  1  one-cycle request to send a zero-length packet
- i_pkt_ack  in  1  host ACKed the last packet sent
- i_pkt_retry  in  1  packet must be resent (timeout/NAK)
- i_status_done  in  1  status stage completed, or a new SETUP aborts the transfer
- o_busy  out  1  transfer in progress
- o_stall  out  1  request unsupported; level, held until next i_setup_val

## Operation
- Accepted requests: bmRequestType 8'h80, bRequest 8'h06. Any other request sets o_stall.
- Selection by wValue[15:8]:
  - 1: device descriptor.
  - 2: configuration descriptor; hscfg when i_hs_mode, else fscfg. If the selected length is 0, use the other one.
  - 3: string; index wValue[7:0] selects 0 lang, 1 vendor, 2 product, 3 serial.
  - 6: qualifier.
  - 7: see Configuration.
- Stall conditions: unknown type; selected length 0; string request when i_descrom_have_strings = 0; string index > 3.
- Transfer length N = min(wLength, len), kept 16-bit internally.
- ZLP needed when N < wLength and N mod MAXPKT = 0; this includes N = 0 with wLength > 0.
- wLength = 0: no data stage; block returns to IDLE and o_busy drops.
- State machine:
  - IDLE: on i_setup_val go to LOOKUP.
  - LOOKUP: one cycle; go to SEND, ZLP, STALL or IDLE.
  - SEND: stream bytes of the current packet. After the byte with o_tx_last go to WAIT_ACK.
  - WAIT_ACK:
    - i_pkt_ack: advance the packet base. Go to SEND if bytes remain, ZLP if needed, else DONE.
    - i_pkt_retry: rewind to the packet base and go to SEND (or ZLP).
    - Both asserted in the same cycle: ack wins.
  - ZLP: pulse o_tx_zlp, then WAIT_ACK. A retry re-pulses it.
  - DONE: hold until i_status_done, then go to IDLE.
  - STALL: hold until i_setup_val.
- i_setup_val in any state aborts the current transfer and restarts from LOOKUP.
- i_status_done in SEND/WAIT_ACK/ZLP aborts to IDLE.
- Byte counters and packet base are 16-bit. ROM address = table addr + offset, modulo 1024.

## Timing
- Reset values:
  - o_tx_val, o_tx_last, o_tx_zlp, o_busy, o_stall = 0.
  - o_descrom_raddr = 0.
  - State = IDLE.
- i_setup_val at cycle t: LOOKUP at t+1; first o_tx_val (or o_stall, or o_tx_zlp) at t+2.
- A byte transfers on a cycle with o_tx_val && i_tx_rdy. o_descrom_raddr increments on the same edge.
- With i_tx_rdy held high, throughput is 1 byte/cycle.
- o_tx_val stays high in SEND regardless of i_tx_rdy. o_tx_dat and o_tx_last are stable while stalled.
- o_tx_last is high on byte MAXPKT of a packet, or on the final byte of N.
- i_pkt_ack/i_pkt_retry are sampled only in WAIT_ACK. The next packet's first o_tx_val follows one cycle after the ack.
- o_busy is high from LOOKUP through DONE.

## Configuration
- USB_DESC_OTHER_SPEED_EN defined:
  - Type 7 (other-speed configuration) returns the non-current-speed config: fscfg when i_hs_mode, else hscfg.
  - The config data source uses the same length-0 rule as type 2: if the selected config length is 0, the other config is used.
  - Payload byte at offset 1 is forced to 8'h07; all other bytes pass through.
  - Stall if the selected length is 0.
- Undefined: type 7 stalls, and no byte override logic is present.

## Test plan
- Device descriptor, dev addr 0, len 18, wLength 64, rdy high:
  - 18 bytes stream from ROM 0..17, o_tx_last on byte 18.
  - After ack: no ZLP (18 mod 64 ≠ 0), go to DONE.
- Config descriptor, hscfg len 64, i_hs_mode=1, wLength 255:
  - 64 bytes with o_tx_last on byte 64.
  - After ack: o_tx_zlp pulses; after the second ack, DONE.
- Device descriptor, wLength 8: 8 bytes, o_tx_last on byte 8, then DONE; later bytes never read.
- Device descriptor, i_pkt_retry asserted after the first packet: the identical 18 bytes are resent from address 0, then ack moves to DONE.
- Error requests, each expected to assert o_stall with o_tx_val staying 0:
  - wValue 16'h0302 with product len 0.
  - bRequest 8'h00.
  - Type 7 with the macro undefined.
- Abort and backpressure:
  - i_setup_val mid-SEND restarts at the new descriptor.
  - RESET asserted mid-packet drops all outputs to 0 asynchronously.
  - Toggling i_tx_rdy holds o_tx_dat stable.
